// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch / load-store memory arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    LD_WAIT = 2'd2,
    ST_WAIT = 2'd3
  } arb_state_t;

  localparam int RD_W = 4;
endpackage

// File: rtl/mem_arbiter.sv
// Two-requester single-outstanding memory arbiter; grant N -> mem_req N+1, ack M -> response pulse M+1.
// Grants only in IDLE without flush; MEM_ARB_RR_EN selects round-robin instead of load/store-first priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  input  logic [RD_W-1:0]     ls_rd,
  output logic                ls_gnt,
  output logic                ld_valid,
  output logic [RD_W-1:0]     ld_rd,
  output logic [DATA_W-1:0]   ld_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  localparam int STRB_W = DATA_W / 8;

  arb_state_t          r_state;
  logic                r_kill;
  logic                r_mem_req;
  logic                r_busy;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [STRB_W-1:0]   r_mem_wstrb;
  logic [RD_W-1:0]     r_rd;
  logic                r_if_rvalid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic                r_ld_valid;
  logic [RD_W-1:0]     r_ld_rd;
  logic [DATA_W-1:0]   r_ld_data;

  logic w_can_grant;
  logic w_if_gnt;
  logic w_ls_gnt;
  logic w_drop;

  assign w_can_grant = (r_state == IDLE) && !flush && !reset;

`ifdef MEM_ARB_RR_EN
  // r_last_ls = 0 means fetch won last, so load/store wins the next conflict.
  logic r_last_ls;

  assign w_ls_gnt = w_can_grant && ls_req && (!if_req || !r_last_ls);
  assign w_if_gnt = w_can_grant && if_req && (!ls_req || r_last_ls);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_ls <= 1'b0;
    end else if (w_ls_gnt || w_if_gnt) begin
      r_last_ls <= w_ls_gnt;
    end
  end
`else
  assign w_ls_gnt = w_can_grant && ls_req;
  assign w_if_gnt = w_can_grant && if_req && !ls_req;
`endif

  // A flush coincident with the ack still kills that response.
  assign w_drop = r_kill || flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_kill      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_rd        <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ld_valid  <= 1'b0;
      r_ld_rd     <= '0;
      r_ld_data   <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_ld_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ls_gnt) begin
            r_mem_addr  <= ls_addr;
            r_mem_we    <= ls_we;
            r_mem_wdata <= ls_wdata;
            r_mem_wstrb <= ls_wstrb;
            r_rd        <= ls_rd;
            r_mem_req   <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ls_we ? ST_WAIT : LD_WAIT;
          end else if (w_if_gnt) begin
            r_mem_addr  <= if_addr;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_mem_req   <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= IF_WAIT;
          end
        end
        IF_WAIT, LD_WAIT: begin
          if (mem_ack) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
            r_kill    <= 1'b0;
            if (!w_drop && (r_state == IF_WAIT)) begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= mem_rdata;
            end
            if (!w_drop && (r_state == LD_WAIT)) begin
              r_ld_valid <= 1'b1;
              r_ld_rd    <= r_rd;
              r_ld_data  <= mem_rdata;
            end
          end else if (flush) begin
            r_kill <= 1'b1;
          end
        end
        ST_WAIT: begin
          // Stores ignore flush entirely once granted.
          if (mem_ack) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
            r_kill    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_gnt    = w_if_gnt;
  assign ls_gnt    = w_ls_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign ld_valid  = r_ld_valid;
  assign ld_rd     = r_ld_rd;
  assign ld_data   = r_ld_data;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign busy      = r_busy;
endmodule
